// File: rtl/serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// full_adder
//   Shared 1-bit full adder cell. serial_adder_ctrl time-multiplexes a single
//   instance of it to build a WIDTH-bit adder.
//
//   Ports:
//     x, y  : addend bits
//     cin   : carry in
//     sum   : x ^ y ^ cin
//     cout  : majority(x, y, cin)
// ---------------------------------------------------------------------------
module full_adder (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = x ^ y ^ cin;
    assign cout = (x & y) | (x & cin) | (y & cin);

endmodule

// ---------------------------------------------------------------------------
// serial_adder_ctrl
//   Bit-serial WIDTH-bit adder. One full_adder cell processes one bit per
//   clock, LSB first. A start/busy/done handshake sequences each addition.
//   The result is registered and holds until the next result is ready.
//
//   Parameters:
//     WIDTH : operand and sum width in bits (>= 2)
//
//   Ports:
//     clk   : system clock, rising edge
//     rst   : synchronous active-high reset
//     start : request an addition (accepted in IDLE or DONE)
//     a, b  : operands, captured on the accepting edge only
//     cin   : carry-in, captured on the accepting edge only
//     busy  : high while the addition runs (WIDTH cycles)
//     done  : one-cycle pulse, sum/cout are valid from this cycle on
//     sum   : registered (a + b + cin) mod 2^WIDTH
//     cout  : registered carry-out of bit WIDTH-1
// ---------------------------------------------------------------------------
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] s_sh;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic fa_sum;
    logic fa_cout;

    // A request is accepted from IDLE or from the DONE cycle, which doubles as
    // the next accepting cycle. start is ignored while RUN is in progress.
    logic accept;
    logic last_bit;

    assign accept   = start && (state != RUN);
    assign last_bit = (state == RUN) && (cnt == LAST_BIT);

    // -----------------------------------------------------------------------
    // The single shared cell always sees the current LSBs and the carry.
    // Its outputs are used only while in RUN.
    // -----------------------------------------------------------------------
    full_adder u_fa (
        .x    (a_sh[0]),
        .y    (b_sh[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, regardless of the order the blocks evaluate.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    // NOTE: next_state gets a default before the case, so no path through
    // the block leaves it unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (cnt == LAST_BIT) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = start ? RUN : IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs, decoded from registered state only
    // -----------------------------------------------------------------------
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath: operand shifters, accumulator, carry, bit counter
    // -----------------------------------------------------------------------
    // NOTE: every datapath register is cleared on reset, so an aborted
    // addition leaves no stale operand or partial sum behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            s_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
        end else if (state == RUN) begin
            // Each new sum bit enters at the top, so after WIDTH shifts
            // bit 0 of the operands has landed in s_sh[0].
            s_sh  <= {fa_sum, s_sh[WIDTH-1:1]};
            carry <= fa_cout;
            a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
            cnt   <= cnt + CNT_W'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Result registers: updated only on the RUN->DONE edge. The last sum bit
    // is merged directly here rather than read from s_sh a cycle later, so
    // the result is valid in the DONE cycle itself.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            sum  <= '0;
            cout <= 1'b0;
        end else if (last_bit) begin
            sum  <= {fa_sum, s_sh[WIDTH-1:1]};
            cout <= fa_cout;
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int n_pass  = 0;
    int n_total = 0;
    int cycle   = 0;

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Advance one clock and sample #1 after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called #1 after an edge with the DUT idle. Presents one request, then
    // returns at the sample point where done is high (or when the budget runs out).
    task automatic run_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                           input logic c, output int busy_cycles, output bit timed_out);
        a = x; b = y; cin = c; start = 1'b1;
        step();                       // E0: accepting edge
        start = 1'b0;
        a = ~x; b = ~y; cin = ~c;     // operands must already be captured
        busy_cycles = 0;
        timed_out = 1'b1;
        for (int i = 0; i < 3 * WIDTH; i++) begin
            if (done) begin
                timed_out = 1'b0;
                break;
            end
            if (busy) busy_cycles++;
            step();
        end
    endtask

    // Directed addition with full handshake checks.
    task automatic directed(input string tag, input logic [WIDTH-1:0] x,
                            input logic [WIDTH-1:0] y, input logic c,
                            input logic [WIDTH-1:0] exp_sum, input logic exp_cout);
        int  bc;
        bit  to;
        run_add(x, y, c, bc, to);
        check({tag, "_timeout"}, 32'(to), 32'd0);
        check({tag, "_busy_cycles"}, 32'(bc), 32'(WIDTH));
        check({tag, "_sum"}, 32'(sum), 32'(exp_sum));
        check({tag, "_cout"}, 32'(cout), 32'(exp_cout));
        step();
        check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int  bc;
        bit  to;
        int  extra_done;
        int  last_done_cycle;
        logic [WIDTH-1:0] bb_a   [3];
        logic [WIDTH-1:0] bb_b   [3];
        logic             bb_c   [3];
        logic [WIDTH-1:0] bb_sum [3];
        logic             bb_co  [3];
        logic [WIDTH-1:0] hold_sum;
        logic [WIDTH-1:0] rx, ry;
        logic             rc;
        logic [WIDTH:0]   ref_sum;

        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;

        // ---- reset state ----
        step();
        step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        rst = 1'b0;
        step();

        // ---- basic additions ----
        directed("zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        directed("ff_p_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        directed("a5_p_5a_c", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1);
        directed("3c_p_0f", 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0);

        // ---- start pulsed mid-RUN is ignored ----
        a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
        step();                       // accept 0x01+0x01
        start = 1'b0;
        step();
        step();
        check("midrun_sum_held", 32'(sum), 32'h4B);
        a = 8'h10; b = 8'h20; start = 1'b1;
        step();
        start = 1'b0;
        to = 1'b1;
        for (int i = 0; i < 3 * WIDTH; i++) begin
            if (done) begin
                to = 1'b0;
                break;
            end
            step();
        end
        check("midrun_timeout", 32'(to), 32'd0);
        check("midrun_sum", 32'(sum), 32'h02);
        check("midrun_cout", 32'(cout), 32'd0);
        extra_done = 0;
        for (int i = 0; i < 2 * WIDTH; i++) begin
            step();
            if (done || busy) extra_done++;
        end
        check("midrun_no_second_op", 32'(extra_done), 32'd0);

        // ---- back-to-back with start held high ----
        bb_a[0] = 8'h12; bb_b[0] = 8'h34; bb_c[0] = 1'b0; bb_sum[0] = 8'h46; bb_co[0] = 1'b0;
        bb_a[1] = 8'h80; bb_b[1] = 8'h80; bb_c[1] = 1'b1; bb_sum[1] = 8'h01; bb_co[1] = 1'b1;
        bb_a[2] = 8'h55; bb_b[2] = 8'h0A; bb_c[2] = 1'b0; bb_sum[2] = 8'h5F; bb_co[2] = 1'b0;
        hold_sum = 8'h02;
        last_done_cycle = 0;
        a = bb_a[0]; b = bb_b[0]; cin = bb_c[0]; start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();                   // accepting edge for operation k
            if (k < 2) begin
                a = bb_a[k+1]; b = bb_b[k+1]; cin = bb_c[k+1];
            end else begin
                start = 1'b0;
            end
            to = 1'b1;
            for (int i = 0; i < 3 * WIDTH; i++) begin
                if (done) begin
                    to = 1'b0;
                    break;
                end
                if (i == WIDTH / 2)
                    check($sformatf("b2b%0d_sum_hold", k), 32'(sum), 32'(hold_sum));
                step();
            end
            check($sformatf("b2b%0d_timeout", k), 32'(to), 32'd0);
            check($sformatf("b2b%0d_sum", k), 32'(sum), 32'(bb_sum[k]));
            check($sformatf("b2b%0d_cout", k), 32'(cout), 32'(bb_co[k]));
            if (k > 0)
                check($sformatf("b2b%0d_spacing", k), 32'(cycle - last_done_cycle), 32'(WIDTH + 1));
            last_done_cycle = cycle;
            hold_sum = bb_sum[k];
        end
        step();
        check("b2b_idle_after", 32'({busy, done}), 32'd0);

        // ---- reset aborts mid-RUN ----
        a = 8'hFF; b = 8'hFF; cin = 1'b0; start = 1'b1;
        step();                       // E0
        start = 1'b0;
        step();                       // E1
        step();                       // E2
        step();                       // E3
        rst = 1'b1;
        step();                       // E4 with rst
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        extra_done = 0;
        for (int i = 0; i < 2 * WIDTH; i++) begin
            step();
            if (done || busy) extra_done++;
        end
        check("abort_no_done", 32'(extra_done), 32'd0);
        directed("after_abort", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);

        // ---- random operations against a WIDTH+1 bit reference ----
        for (int n = 0; n < 1000; n++) begin
            rx = WIDTH'($urandom);
            ry = WIDTH'($urandom);
            rc = 1'($urandom);
            ref_sum = (WIDTH+1)'(rx) + (WIDTH+1)'(ry) + (WIDTH+1)'(rc);
            run_add(rx, ry, rc, bc, to);
            if (to) begin
                check($sformatf("rand%0d_timeout", n), 32'(to), 32'd0);
                break;
            end
            check($sformatf("rand%0d_%0h_%0h_%0h", n, rx, ry, rc), 32'({cout, sum}), 32'(ref_sum));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
